// File: rtl/key_debounce.sv
// Push-button debouncer with a four-state press/release FSM, edge strobes and a press counter.
// Slide switches are only synchronised to clk; they are not debounced.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1250000,
  parameter int CNT_W           = 21
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_n,
  input  logic [1:0] sw,
  output logic       key_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic [1:0] sw_sync,
  output logic [7:0] press_count
);

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       key_sync;
  logic [1:0]       sw_meta;
  logic             key_p;
  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             press_set;
  logic             release_set;

  // Key idles high (released) so its synchroniser resets to 1s.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_sync <= 2'b11;
      sw_meta  <= 2'b00;
      sw_sync  <= 2'b00;
    end else begin
      key_sync <= {key_sync[0], key_n};
      sw_meta  <= sw;
      sw_sync  <= sw_meta;
    end
  end

  assign key_p = ~key_sync[1];

  // Registered FSM state, counter and outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= RELEASED;
      cnt           <= CNT_ZERO;
      key_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      press_count   <= 8'd0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      press_pulse   <= press_set;
      release_pulse <= release_set;
      if (press_set) begin
        key_level   <= 1'b1;
        press_count <= press_count + 8'd1;
      end else if (release_set) begin
        key_level   <= 1'b0;
      end else begin
        key_level   <= key_level;
      end
    end
  end

  // Next-state and counter: any disagreement with the held level must persist
  // for DEBOUNCE_CYCLES consecutive samples; one agreeing sample restarts it.
  always_comb begin
    state_nxt = RELEASED;
    cnt_nxt   = CNT_ZERO;
    case (state)
      RELEASED: begin
        if (key_p) begin
          state_nxt = PRESS_CHK;
          cnt_nxt   = CNT_ONE;
        end else begin
          state_nxt = RELEASED;
          cnt_nxt   = CNT_ZERO;
        end
      end
      PRESS_CHK: begin
        if (!key_p) begin
          state_nxt = RELEASED;
          cnt_nxt   = CNT_ZERO;
        end else if (cnt == CNT_MAX) begin
          state_nxt = PRESSED;
          cnt_nxt   = CNT_ZERO;
        end else begin
          state_nxt = PRESS_CHK;
          cnt_nxt   = cnt + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!key_p) begin
          state_nxt = RELEASE_CHK;
          cnt_nxt   = CNT_ONE;
        end else begin
          state_nxt = PRESSED;
          cnt_nxt   = CNT_ZERO;
        end
      end
      RELEASE_CHK: begin
        if (key_p) begin
          state_nxt = PRESSED;
          cnt_nxt   = CNT_ZERO;
        end else if (cnt == CNT_MAX) begin
          state_nxt = RELEASED;
          cnt_nxt   = CNT_ZERO;
        end else begin
          state_nxt = RELEASE_CHK;
          cnt_nxt   = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = RELEASED;
        cnt_nxt   = CNT_ZERO;
      end
    endcase
  end

  // Strobe requests; registered into press_pulse/release_pulse above.
  always_comb begin
    press_set   = 1'b0;
    release_set = 1'b0;
    case (state)
      PRESS_CHK: begin
        if (key_p && (cnt == CNT_MAX)) begin
          press_set = 1'b1;
        end else begin
          press_set = 1'b0;
        end
      end
      RELEASE_CHK: begin
        if (!key_p && (cnt == CNT_MAX)) begin
          release_set = 1'b1;
        end else begin
          release_set = 1'b0;
        end
      end
      default: begin
        press_set   = 1'b0;
        release_set = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce with DEBOUNCE_CYCLES = 4: directed scenarios
// plus randomized key/switch activity compared against a run-length reference model.
module tb_key_debounce;

  localparam int D = 4;

  logic       clk;
  logic       rst_n;
  logic       key_n;
  logic [1:0] sw;
  logic       key_level;
  logic       press_pulse;
  logic       release_pulse;
  logic [1:0] sw_sync;
  logic [7:0] press_count;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  key_debounce #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .key_n(key_n), .sw(sw),
    .key_level(key_level), .press_pulse(press_pulse), .release_pulse(release_pulse),
    .sw_sync(sw_sync), .press_count(press_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: what the FSM sees is the raw pin two edges late; a level
  // change is accepted once the opposite level has been seen D times in a row.
  logic [1:0] m_hist_key;
  logic [1:0] m_hist_sw0;
  logic [1:0] m_hist_sw1;
  int         m_run;
  logic       m_level;
  logic       m_press;
  logic       m_rel;
  logic [7:0] m_count;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hist_key <= 2'b11;
      m_hist_sw0 <= 2'b00;
      m_hist_sw1 <= 2'b00;
      m_run      <= 0;
      m_level    <= 1'b0;
      m_press    <= 1'b0;
      m_rel      <= 1'b0;
      m_count    <= 8'd0;
    end else begin
      m_hist_key <= {m_hist_key[0], key_n};
      m_hist_sw0 <= {m_hist_sw0[0], sw[0]};
      m_hist_sw1 <= {m_hist_sw1[0], sw[1]};
      m_press    <= 1'b0;
      m_rel      <= 1'b0;
      if ((!m_hist_key[1]) != m_level) begin
        if (m_run + 1 >= D) begin
          m_run   <= 0;
          m_level <= !m_level;
          if (!m_level) begin
            m_press <= 1'b1;
            m_count <= m_count + 8'd1;
          end else begin
            m_rel <= 1'b1;
          end
        end else begin
          m_run <= m_run + 1;
        end
      end else begin
        m_run <= 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    key_n = 1'b1;
    sw    = 2'b00;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    key_n = 1'b0;
    sw    = 2'b11;
    repeat (8) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({key_level, press_pulse, release_pulse, sw_sync, press_count} !== 13'd0) begin
      fails++;
      $display("FAIL reset_outputs: got lvl=%b pp=%b rp=%b sw=%b cnt=%0d, want all 0",
               key_level, press_pulse, release_pulse, sw_sync, press_count);
    end else passes++;
    key_n = 1'b1;
    sw    = 2'b00;
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_clean_press();
    do_reset();
    key_n = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      checks++;
      if (press_pulse !== (i == 6) || key_level !== (i >= 6)) begin
        fails++;
        $display("FAIL clean_press edge %0d: got pp=%b lvl=%b, want pp=%b lvl=%b",
                 i, press_pulse, key_level, (i == 6), (i >= 6));
      end else passes++;
    end
    checks++;
    if (press_count !== 8'd1) begin
      fails++;
      $display("FAIL clean_press_count: got %0d, want 1", press_count);
    end else passes++;
  endtask

  task automatic test_release();
    key_n = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      checks++;
      if (release_pulse !== (i == 6) || press_pulse !== 1'b0 || key_level !== (i < 6)) begin
        fails++;
        $display("FAIL release edge %0d: got rp=%b pp=%b lvl=%b, want rp=%b pp=0 lvl=%b",
                 i, release_pulse, press_pulse, key_level, (i == 6), (i < 6));
      end else passes++;
    end
  endtask

  task automatic test_bounce();
    int seen;
    seen = 0;
    do_reset();
    for (int seg = 0; seg < 4; seg++) begin
      key_n = (seg % 2 == 0) ? 1'b0 : 1'b1;
      repeat ((seg % 2 == 0) ? 3 : 1) begin
        tick();
        if (press_pulse || key_level) seen++;
      end
    end
    repeat (8) begin
      tick();
      if (press_pulse || key_level) seen++;
    end
    checks++;
    if (seen != 0 || press_count !== 8'd0) begin
      fails++;
      $display("FAIL bounce: got %0d active cycles, count=%0d, want 0 and 0", seen, press_count);
    end else passes++;
  endtask

  task automatic test_wrap();
    int pulses;
    int bad;
    pulses = 0;
    bad    = 0;
    do_reset();
    for (int n = 0; n < 256; n++) begin
      key_n = 1'b0;
      repeat (8) begin
        tick();
        if (press_pulse) pulses++;
      end
      if (press_count !== 8'((n + 1) % 256)) bad++;
      key_n = 1'b1;
      repeat (8) begin
        tick();
        if (press_pulse) pulses++;
      end
    end
    checks++;
    if (pulses != 256 || press_count !== 8'd0 || bad != 0) begin
      fails++;
      $display("FAIL wrap: got pulses=%0d count=%0d badsteps=%0d, want 256, 0, 0",
               pulses, press_count, bad);
    end else passes++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    key_n = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({key_level, press_pulse, release_pulse, sw_sync, press_count} !== 13'd0) begin
      fails++;
      $display("FAIL reset_mid_outputs: got lvl=%b pp=%b rp=%b cnt=%0d, want all 0",
               key_level, press_pulse, release_pulse, press_count);
    end else passes++;
    repeat (3) tick();
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      checks++;
      if (press_pulse !== (i == 6)) begin
        fails++;
        $display("FAIL reset_mid_press edge %0d: got pp=%b, want %b", i, press_pulse, (i == 6));
      end else passes++;
    end
  endtask

  task automatic test_switches();
    do_reset();
    sw = 2'b10;
    tick();
    checks++;
    if (sw_sync !== 2'b00) begin
      fails++;
      $display("FAIL sw_edge1: got %b, want 00", sw_sync);
    end else passes++;
    tick();
    checks++;
    if (sw_sync !== 2'b10) begin
      fails++;
      $display("FAIL sw_edge2: got %b, want 10", sw_sync);
    end else passes++;
    rst_n = 1'b0;
    sw    = 2'b11;
    repeat (3) begin
      tick();
      checks++;
      if (sw_sync !== 2'b00) begin
        fails++;
        $display("FAIL sw_in_reset: got %b, want 00", sw_sync);
      end else passes++;
    end
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    int len;
    do_reset();
    for (int seg = 0; seg < 300; seg++) begin
      key_n = 1'($urandom_range(0, 1));
      sw    = 2'($urandom_range(0, 3));
      len   = $urandom_range(1, 7);
      repeat (len) begin
        tick();
        checks++;
        if (key_level !== m_level || press_pulse !== m_press || release_pulse !== m_rel ||
            press_count !== m_count || sw_sync !== {m_hist_sw1[1], m_hist_sw0[1]} ||
            (press_pulse && release_pulse)) begin
          fails++;
          $display("FAIL random seg %0d: got lvl=%b pp=%b rp=%b cnt=%0d sw=%b, want lvl=%b pp=%b rp=%b cnt=%0d sw=%b",
                   seg, key_level, press_pulse, release_pulse, press_count, sw_sync,
                   m_level, m_press, m_rel, m_count, {m_hist_sw1[1], m_hist_sw0[1]});
        end else passes++;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    key_n = 1'b1;
    sw    = 2'b00;
    test_reset();
    test_clean_press();
    test_release();
    test_bounce();
    test_reset_mid();
    test_switches();
    test_random();
    test_wrap();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
